// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard/forwarding controller.
//   REG_AW        register-index width; sizes the shadow stage records
//   fwd_sel_e     ALU operand source select
//   pc_src_e      next-PC source select
//   st_state_e    stall-sequence tracking state
//   shadow_stage_t destination/source info mirrored from one datapath pipeline register
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    ST1 = 2'd1,
    ST2 = 2'd2
  } st_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              regWrite;
    logic              memRead;
  } shadow_stage_t;

  // A stage produces register r; $0 is hardwired and never counts as a producer.
  function automatic logic regMatch(input logic              regWrite,
                                    input logic [REG_AW-1:0] dest,
                                    input logic [REG_AW-1:0] r);
    return regWrite && (dest != '0) && (dest == r);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: EX-stage ALU operand forwarding selects, purely combinational.
//   idex, exmem, memwb  in   shadow copies of the three pipeline registers
//   aSel, bSel          out  operand source (FWD_REG / FWD_MEM / FWD_WB)
module fwd_unit
  import hazard_pkg::*;
(
  input  shadow_stage_t idex,
  input  shadow_stage_t exmem,
  input  shadow_stage_t memwb,
  output logic [1:0]    aSel,
  output logic [1:0]    bSel
);

  fwd_sel_e aSrc;
  fwd_sel_e bSrc;

  // EX/MEM is checked first: it holds the youngest value of a register.
  always_comb begin
    aSrc = FWD_REG;
    bSrc = FWD_REG;
    if (regMatch(exmem.regWrite, exmem.dest, idex.rs)) begin
      aSrc = FWD_MEM;
    end else if (regMatch(memwb.regWrite, memwb.dest, idex.rs)) begin
      aSrc = FWD_WB;
    end
    if (regMatch(exmem.regWrite, exmem.dest, idex.rt)) begin
      bSrc = FWD_MEM;
    end else if (regMatch(memwb.regWrite, memwb.dest, idex.rt)) begin
      bSrc = FWD_WB;
    end
  end

  assign aSel = 2'(aSrc);
  assign bSel = 2'(bSrc);

  // Source fields of older stages and destinations of the EX stage play no part here.
  logic unusedFields;
  assign unusedFields = ^{idex.dest, idex.regWrite, idex.memRead,
                          exmem.rs, exmem.rt, exmem.memRead,
                          memwb.rs, memwb.rt, memwb.memRead};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Mirrors ID/EX, EX/MEM and MEM/WB destination info and derives PC/IF-ID enables,
// IF flush, bubble select, PC source and EX operand forwarding selects.
//   clk, rst                         clock, asynchronous active-high reset
//   idRs/idRt/idRd, idRegDst         ID-stage register fields and destination select
//   idRegWrite/idMemRead             ID instruction writes a register / is a load
//   idUsesRs/idUsesRt                ID instruction reads rs / rt
//   idBranch/idJump/equal            beq, j, ID comparator result
//   pcSrc, pcWrite, ifidWrite        next-PC source and load enables
//   ifFlush, controlSel, stall       IF/ID clear, 0 = bubble into ID/EX, stall active
//   aSel, bSel                       ALU operand forwarding selects
// Optional: define HAZARD_PERF_EN to add stallCount/flushCount [CNT_W-1:0] counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic [REG_AW-1:0] idRd,
  input  logic              idRegDst,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic              idBranch,
  input  logic              idJump,
  input  logic              equal,
  output logic [1:0]        pcSrc,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              ifFlush,
  output logic              controlSel,
  output logic              stall,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  flushCount,
`endif
  output logic [1:0]        aSel,
  output logic [1:0]        bSel
);

  if (CNT_W == 0) begin : gCntWCheck
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  shadow_stage_t idex;
  shadow_stage_t exmem;
  shadow_stage_t memwb;
  shadow_stage_t idNext;

  st_state_e stState;
  st_state_e stNext;
  pc_src_e   pcSrcSel;

  logic rsEx;
  logic rtEx;
  logic rsMem;
  logic rtMem;
  logic loadUse;
  logic branchHaz;
  logic hazard;

  // ID-stage record as it would enter ID/EX.
  always_comb begin
    idNext          = '0;
    idNext.rs       = idRs;
    idNext.rt       = idRt;
    idNext.dest     = idRegDst ? idRd : idRt;
    idNext.regWrite = idRegWrite;
    idNext.memRead  = idMemRead;
  end

  // Shadow pipe advances every edge like the datapath; a stall injects a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex  <= stall ? '0 : idNext;
      exmem <= idex;
      memwb <= exmem;
    end
  end

  // Hazard detection; MEM/WB never stalls because the register file writes through.
  always_comb begin
    rsEx      = regMatch(idex.regWrite, idex.dest, idRs);
    rtEx      = regMatch(idex.regWrite, idex.dest, idRt);
    rsMem     = regMatch(exmem.regWrite, exmem.dest, idRs);
    rtMem     = regMatch(exmem.regWrite, exmem.dest, idRt);
    loadUse   = idex.memRead && ((idUsesRs && rsEx) || (idUsesRt && rtEx));
    // Branch operands are compared in ID without forwarding, so any EX or MEM producer stalls.
    branchHaz = idBranch && (rsEx || rtEx || rsMem || rtMem);
    hazard    = loadUse || branchHaz;
  end

  // Stall-sequence state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stState <= RUN;
    end else begin
      stState <= stNext;
    end
  end

  // Next state and pipeline control; a stall overrides any jump or taken branch.
  always_comb begin
    stNext     = stState;
    pcSrcSel   = PC_INC;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    controlSel = 1'b1;
    ifFlush    = 1'b0;
    stall      = 1'b0;

    if (hazard) begin
      stall      = 1'b1;
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      controlSel = 1'b0;
    end else if (idJump) begin
      pcSrcSel = PC_JMP;
      ifFlush  = 1'b1;
    end else if (idBranch && equal) begin
      pcSrcSel = PC_BR;
      ifFlush  = 1'b1;
    end

    case (stState)
      RUN:     stNext = hazard ? ST1 : RUN;
      ST1:     stNext = hazard ? ST2 : RUN;
      ST2:     stNext = RUN;
      default: stNext = RUN;
    endcase
  end

  assign pcSrc = 2'(pcSrcSel);

  // At most two back-to-back stall cycles can legally occur.
  assert property (@(posedge clk) disable iff (rst) !((stState == ST2) && hazard))
    else $error("hazard_ctrl: third consecutive stall cycle");

  fwd_unit uFwd (
    .idex  (idex),
    .exmem (exmem),
    .memwb (memwb),
    .aSel  (aSel),
    .bSel  (bSel)
  );

`ifdef HAZARD_PERF_EN
  // Free-running event counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall) begin
        stallCount <= stallCount + CNT_W'(1);
      end
      if (ifFlush) begin
        flushCount <= flushCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule
